// File: rtl/gol_pkg.sv
// gol_pkg: shared types and bank-index helper for the Game of Life bank controller
package gol_pkg;
    localparam int BANK_IDX_W = 2;
    typedef enum logic {
        CTRL_CLEAR = 1'b0,
        CTRL_RUN   = 1'b1
    } ctrl_state_t;
    // Index of the bank that is neither a nor b (banks numbered 0..2)
    function automatic logic [BANK_IDX_W-1:0] third_bank(input logic [BANK_IDX_W-1:0] a,
                                                         input logic [BANK_IDX_W-1:0] b);
        return BANK_IDX_W'(3) - a - b;
    endfunction
endpackage

// File: rtl/gol_bank_ram.sv
// gol_bank_ram: one cell bank with a read/write engine port A and a display read port B
module gol_bank_ram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              we_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    // Cell storage is left unreset so it maps onto block RAM
    always_ff @(posedge clk)
        if (we_a) mem[addr_a] <= wdata_a;
    // Registered read data; port A returns the old cell on a simultaneous write
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= mem[addr_a];
            rdata_b <= mem[addr_b];
        end
endmodule

// File: rtl/gol_bank_ctrl.sv
// gol_bank_ctrl: N-bank rotating cell memory with frame-synchronised rotation and clear sweep
module gol_bank_ctrl
    import gol_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 4,
    parameter int NUM_BANKS = 2,
    parameter int SYNC_SWAP = 1,
    parameter int CLEAR_VAL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     eng_raddr,
    output logic [DATA_W-1:0]     eng_rdata,
    input  logic [ADDR_W-1:0]     eng_waddr,
    input  logic [DATA_W-1:0]     eng_wdata,
    input  logic                  eng_we,
    input  logic                  gen_done,
    output logic                  gen_ack,
    output logic                  eng_stall,
    input  logic [ADDR_W-1:0]     disp_addr,
    output logic [DATA_W-1:0]     disp_data,
    input  logic                  video_sof,
    input  logic                  clear_req,
    output logic                  ready,
    output logic [BANK_IDX_W-1:0] src_idx,
    output logic [BANK_IDX_W-1:0] dst_idx,
    output logic [BANK_IDX_W-1:0] disp_idx,
    output logic [15:0]           gen_count,
    output logic                  err
);
    localparam logic [BANK_IDX_W-1:0] SRC_RST = '0;
    localparam logic [BANK_IDX_W-1:0] DST_RST = BANK_IDX_W'(1);

    ctrl_state_t           state, state_n;
    logic [ADDR_W-1:0]     clr_cnt, clr_cnt_n;
    logic [BANK_IDX_W-1:0] src_n, dst_n, disp_n, src_q, disp_q;
    logic                  pend, pend_n, dpend, dpend_n, ack_n, err_n;
    logic                  clearing, gd_ok, swap;
    logic [15:0]           count_n;
    logic [DATA_W-1:0]     rd_a [4];
    logic [DATA_W-1:0]     rd_b [4];

    assign clearing  = state == CTRL_CLEAR;
    assign ready     = !clearing;
    assign eng_stall = clearing || pend;
    assign gd_ok     = gen_done && !eng_stall;
    // Two-bank swap: pending (or fresh) completion meets start-of-frame, or the cycle after gen_done
    assign swap = (SYNC_SWAP != 0) ? ((pend && !gen_ack) || gd_ok) && video_sof : pend && !gen_ack;

    // Next-state and rotation decisions
    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        src_n     = src_idx;
        dst_n     = dst_idx;
        disp_n    = disp_idx;
        pend_n    = pend;
        dpend_n   = dpend;
        ack_n     = 1'b0;
        count_n   = gen_count + 16'(gen_ack);
        err_n     = err;
        if (clear_req) begin
            state_n   = CTRL_CLEAR;
            clr_cnt_n = '0;
            src_n     = SRC_RST;
            dst_n     = DST_RST;
            disp_n    = SRC_RST;
            pend_n    = 1'b0;
            dpend_n   = 1'b0;
            count_n   = '0;
            err_n     = 1'b0;
        end else if (clearing) begin
            clr_cnt_n = clr_cnt + ADDR_W'(1);
            state_n   = &clr_cnt ? CTRL_RUN : CTRL_CLEAR;
        end else begin
            err_n = err || (gen_done && eng_stall);
            if (NUM_BANKS == 2) begin
                pend_n = gen_ack ? 1'b0 : pend || gd_ok;
                if (swap) begin
                    src_n  = dst_idx;
                    dst_n  = src_idx;
                    disp_n = dst_idx;
                    ack_n  = 1'b1;
                end
            end else if (gd_ok) begin
                src_n = dst_idx;
                ack_n = 1'b1;
                if (video_sof) begin
                    disp_n  = dst_idx;
                    dst_n   = src_idx;
                    dpend_n = 1'b0;
                end else begin
                    dst_n   = third_bank(dst_idx, disp_idx);
                    dpend_n = 1'b1;
                end
            end else if (video_sof && dpend) begin
                disp_n  = src_idx;
                dpend_n = 1'b0;
            end
        end
    end

    // Control state register plus delayed bank selects for the read muxes
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= CTRL_CLEAR;
            clr_cnt   <= '0;
            src_idx   <= SRC_RST;
            dst_idx   <= DST_RST;
            disp_idx  <= SRC_RST;
            pend      <= 1'b0;
            dpend     <= 1'b0;
            gen_ack   <= 1'b0;
            gen_count <= '0;
            err       <= 1'b0;
            src_q     <= SRC_RST;
            disp_q    <= SRC_RST;
        end else begin
            state     <= state_n;
            clr_cnt   <= clr_cnt_n;
            src_idx   <= src_n;
            dst_idx   <= dst_n;
            disp_idx  <= disp_n;
            pend      <= pend_n;
            dpend     <= dpend_n;
            gen_ack   <= ack_n;
            gen_count <= count_n;
            err       <= err_n;
            src_q     <= src_idx;
            disp_q    <= disp_idx;
        end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        if (g < NUM_BANKS) begin : g_ram
            logic is_dst;
            assign is_dst = dst_idx == BANK_IDX_W'(g);
            gol_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
                .clk     (clk),
                .rst     (rst),
                .addr_a  (clearing ? clr_cnt : is_dst ? eng_waddr : eng_raddr),
                .we_a    (clearing || (is_dst && eng_we)),
                .wdata_a (clearing ? DATA_W'(CLEAR_VAL) : eng_wdata),
                .rdata_a (rd_a[g]),
                .addr_b  (disp_addr),
                .rdata_b (rd_b[g])
            );
        end else begin : g_none
            assign rd_a[g] = '0;
            assign rd_b[g] = '0;
        end
    end

    assign eng_rdata = rd_a[src_q];
    assign disp_data = rd_b[disp_q];
endmodule

// File: doc/gol_bank_ctrl.md
Name: gol_bank_ctrl

Overview:
Parametrised multi-bank cell-memory controller for the Game of Life pipeline. It replaces the fixed two-bank ping-pong muxing with an N-bank rotating buffer (N = 2 or 3). It owns the bank RAMs, routes engine read/write and display read traffic, and performs tear-free bank rotation synchronised to video start-of-frame. It also runs a hardware clear sweep of every bank.

Parameters:
ADDR_W, 16, cell address width; each bank holds 2^ADDR_W cells
DATA_W, 4, cell width (species/state code)
NUM_BANKS, 2, number of banks; legal values 2 or 3
SYNC_SWAP, 1, 1 = 2-bank swap deferred to video_sof; 0 = swap on the cycle after gen_done
CLEAR_VAL, 0, value written to every cell during a clear sweep

Ports:
clk  in  1  pixel clock, sole clock
rst  in  1  asynchronous active-high reset
eng_raddr  in  ADDR_W  engine read address (source bank)
eng_rdata  out  DATA_W  source-bank data, 1-cycle latency
eng_waddr  in  ADDR_W  engine write address (destination bank)
eng_wdata  in  DATA_W  engine write data
eng_we  in  1  engine write strobe
gen_done  in  1  one-cycle pulse: destination bank holds a complete generation
gen_ack  out  1  one-cycle pulse: rotation applied; engine may start the next generation
eng_stall  out  1  high while clearing or while a swap is pending; engine must hold off
disp_addr  in  ADDR_W  display read address
disp_data  out  DATA_W  display-bank data, 1-cycle latency
video_sof  in  1  one-cycle start-of-frame pulse
clear_req  in  1  pulse: start a clear sweep
ready  out  1  high in RUN state
src_idx  out  2  current source bank
dst_idx  out  2  current destination bank
disp_idx  out  2  current display bank
gen_count  out  16  completed generations, wraps 0xFFFF->0
err  out  1  sticky protocol error; cleared only by rst or a clear sweep

Behaviour:
- Each bank is simple dual-port.
  - Port A: engine side. It reads when the bank is src and writes when the bank is dst.
  - Port B: display read only.
  - src != dst is invariant. No arbitration or stalls exist on reads.
- Read data is registered 1 cycle. The bank-select mux uses a 1-cycle-delayed copy of the index, so a rotation never mixes banks within a read.
- Reset (async):
  - State CLEAR, clear counter 0.
  - src=0, dst=1, disp=0.
  - gen_ack=0, eng_stall=1, ready=0, gen_count=0, err=0.
  - eng_rdata=0, disp_data=0.
  - Swap-pending flag 0.
- CLEAR state:
  - Writes CLEAR_VAL to address cnt in all banks each cycle.
  - After writing address 2^ADDR_W-1, goes to RUN on the next cycle. This is 2^ADDR_W cycles of writes, then ready=1 and eng_stall=0.
  - eng_we and gen_done are ignored. Reads return whatever the RAM holds.
- RUN state, NUM_BANKS=2:
  - disp tracks src.
  - On gen_done, set pending and raise eng_stall next cycle.
  - If SYNC_SWAP=1: when pending (or gen_done) coincides with video_sof, swap src<->dst and set disp=new src. gen_ack pulses the following cycle; pending and eng_stall clear with it. A gen_done and a video_sof in the same cycle swap immediately.
  - If SYNC_SWAP=0: swap on the cycle after gen_done, regardless of video_sof.
- RUN state, NUM_BANKS=3:
  - On gen_done: src<=dst (just completed), dst<=the bank that is neither new src nor disp, and set disp_pending. gen_ack pulses next cycle. eng_stall stays 0.
  - On video_sof with disp_pending: disp<=src, then clear disp_pending. dst is unchanged; it already differs from both.
  - gen_done and video_sof in the same cycle: disp<=the completed bank directly.
  - Two gen_done pulses before a sof: disp jumps to the latest completed bank. dst never equals disp.
- gen_count increments on each gen_ack.
- gen_done while eng_stall=1 is ignored and sets err.
- eng_we while src==dst is impossible by construction.
- clear_req in RUN:
  - Enters CLEAR next cycle. Indices return to reset values; pending, gen_count and err are cleared.
  - An in-flight swap is discarded and no gen_ack is issued.
  - clear_req during CLEAR restarts the counter.

Decomposition:
- Shared package gol_pkg holds:
  - BANK_IDX_W=2 and the CTRL_CLEAR/CTRL_RUN state encodings.
  - The bank-index helper function "third bank", i.e. 3-a-b.
- One sub-module, gol_bank_ram: parametrised ADDR_W/DATA_W simple dual-port RAM, registered read. It is instantiated NUM_BANKS times via generate.

Test Plan:
- ADDR_W=4, rst released -> 16 clear cycles, ready=1 on cycle 17; every address in every bank reads CLEAR_VAL (0).
- NUM_BANKS=2, SYNC_SWAP=1; gen_done at cycle 10, video_sof at cycle 40 -> eng_stall=1 on cycles 11-41; swap at 40; gen_ack at 41; src=1, dst=0, disp=1; gen_count=1.
- NUM_BANKS=2, gen_done and video_sof in the same cycle -> immediate swap, gen_ack next cycle. A second gen_done while stalled -> ignored, err=1.
- NUM_BANKS=3 from src0/dst1/disp0:
  - gen_done -> src=1, dst=2, eng_stall never asserted.
  - Second gen_done before sof -> src=2, dst=1.
  - sof -> disp=2.
- Write 0xA at dst address 5, then rotate -> eng_rdata=0xA one cycle after eng_raddr=5; disp_data=0xA after the display switch.
- clear_req with a swap pending -> no gen_ack; indices 0/1/0; gen_count=0; err=0; ready drops for 2^ADDR_W cycles.
